// File: rtl/iob_pcie_loopback.sv
// PCIe user-channel loopback: buffers one RX transaction, then echoes it or sends an incrementing counter on TX.
// Optional counters XFER_CNT/TRUNC_CNT/ABORT_CNT are enabled by defining IOB_PCIE_LOOPBACK_STATS_EN.
module iob_pcie_loopback #(
   parameter int unsigned C_PCI_DATA_WIDTH = 32,
   parameter int unsigned FIFO_ADDR_W      = 9
) (
   input  logic                        CLK,
   input  logic                        RST,
   output logic                        CHNL_RX_CLK,
   input  logic                        CHNL_RX,
   output logic                        CHNL_RX_ACK,
   input  logic                        CHNL_RX_LAST,
   input  logic [31:0]                 CHNL_RX_LEN,
   input  logic [30:0]                 CHNL_RX_OFF,
   input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
   input  logic                        CHNL_RX_DATA_VALID,
   output logic                        CHNL_RX_DATA_REN,
   output logic                        CHNL_TX_CLK,
   output logic                        CHNL_TX,
   input  logic                        CHNL_TX_ACK,
   output logic                        CHNL_TX_LAST,
   output logic [31:0]                 CHNL_TX_LEN,
   output logic [30:0]                 CHNL_TX_OFF,
   output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
   output logic                        CHNL_TX_DATA_VALID,
   input  logic                        CHNL_TX_DATA_REN,
   input  logic                        MODE,
   output logic                        BUSY
`ifdef IOB_PCIE_LOOPBACK_STATS_EN
   ,
   output logic [31:0]                 XFER_CNT,
   output logic [31:0]                 TRUNC_CNT,
   output logic [31:0]                 ABORT_CNT
`endif
);

   localparam int unsigned W         = C_PCI_DATA_WIDTH / 32;
   localparam int unsigned WL        = $clog2(W);
   localparam int unsigned DEPTH     = 1 << FIFO_ADDR_W;
   localparam int unsigned PW        = FIFO_ADDR_W + 1;
   localparam logic [33:0] CAP_WORDS = 34'(W) << FIFO_ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RX      = 2'd1,
      S_TX_REQ  = 2'd2,
      S_TX_DATA = 2'd3
   } state_t;

   state_t                      state_q, state_d;
   logic [31:0]                 len_q, len_beats_q, rx_beats_q;
   logic [31:0]                 tx_len_q, tx_len_beats_q, tx_beats_q, pat_q;
   logic                        mode_q, ack_q;
   logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
   logic [C_PCI_DATA_WIDTH-1:0] mem [DEPTH];

   logic                        rx_accept, rx_done, rx_abort;
   logic                        fifo_wr, fifo_empty, fifo_full, flush;
   logic                        tx_valid_c, tx_xfer, tx_last, tx_fin;
   logic [31:0]                 rx_len_beats_c, rx_beats_nx, tx_len_nx, tx_len_beats_nx, tx_rem;
   logic [33:0]                 rcvd_words, len_cap;
   logic [C_PCI_DATA_WIDTH-1:0] tx_data_c;
   logic                        unused_in;

   assign unused_in = ^{CHNL_RX_LAST, CHNL_RX_OFF};

   assign CHNL_RX_CLK  = CLK;
   assign CHNL_TX_CLK  = CLK;
   assign CHNL_TX_LAST = 1'b1;
   assign CHNL_TX_OFF  = 31'd0;

   // RX beat bookkeeping; a beat on the same cycle CHNL_RX falls still counts
   assign rx_len_beats_c = 32'((33'(CHNL_RX_LEN) + 33'(W - 1)) >> WL);
   assign rx_accept      = (state_q == S_RX) && CHNL_RX_DATA_VALID;
   assign rx_beats_nx    = rx_beats_q + 32'(rx_accept);
   assign rx_done        = rx_accept && (rx_beats_nx == len_beats_q);
   assign rx_abort       = (state_q == S_RX) && !CHNL_RX && !rx_done;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                       (wr_ptr_q[FIFO_ADDR_W-1:0] == rd_ptr_q[FIFO_ADDR_W-1:0]);
   assign fifo_wr    = rx_accept && (rx_beats_q < DEPTH) && !fifo_full;

   // tx_len = min(len, CAP, W * received beats)
   assign rcvd_words      = 34'(rx_beats_nx) << WL;
   assign len_cap         = (34'(len_q) < CAP_WORDS) ? 34'(len_q) : CAP_WORDS;
   assign tx_len_nx       = 32'((len_cap < rcvd_words) ? len_cap : rcvd_words);
   assign tx_len_beats_nx = 32'((33'(tx_len_nx) + 33'(W - 1)) >> WL);

   assign tx_valid_c = mode_q ? 1'b1 : !fifo_empty;
   assign tx_xfer    = (state_q == S_TX_DATA) && tx_valid_c && CHNL_TX_DATA_REN;
   assign tx_last    = (tx_beats_q + 32'd1) == tx_len_beats_q;
   assign tx_fin     = tx_xfer && tx_last;
   assign tx_rem     = tx_len_q & 32'(W - 1);
   assign flush      = (state_q != S_IDLE) && (state_d == S_IDLE);

   // TX beat assembly; words past tx_len in the final beat are zeroed
   always_comb begin
      tx_data_c = '0;
      for (int unsigned i = 0; i < W; i++) begin
         if (!(tx_last && (tx_rem != 32'd0) && (32'(i) >= tx_rem))) begin
            tx_data_c[i*32 +: 32] = mode_q ? (pat_q + 32'(i))
                                           : mem[rd_ptr_q[FIFO_ADDR_W-1:0]][i*32 +: 32];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (CHNL_RX) state_d = (CHNL_RX_LEN == 32'd0) ? S_TX_REQ : S_RX;
         S_RX:      if (rx_done || rx_abort) state_d = S_TX_REQ;
         S_TX_REQ:  if (CHNL_TX_ACK) state_d = (tx_len_q == 32'd0) ? S_IDLE : S_TX_DATA;
         S_TX_DATA: if (tx_fin) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      CHNL_RX_ACK        = ack_q;
      CHNL_RX_DATA_REN   = 1'b0;
      CHNL_TX            = 1'b0;
      CHNL_TX_LEN        = tx_len_q;
      CHNL_TX_DATA       = '0;
      CHNL_TX_DATA_VALID = 1'b0;
      BUSY               = (state_q != S_IDLE);
      case (state_q)
         S_RX:      CHNL_RX_DATA_REN = 1'b1;
         S_TX_REQ:  CHNL_TX = 1'b1;
         S_TX_DATA: begin
            CHNL_TX            = 1'b1;
            CHNL_TX_DATA_VALID = tx_valid_c;
            CHNL_TX_DATA       = tx_data_c;
         end
         default: ;
      endcase
   end

   // Transaction datapath and FIFO pointers
   always_ff @(posedge CLK) begin
      if (RST) begin
         len_q          <= '0;
         len_beats_q    <= '0;
         rx_beats_q     <= '0;
         tx_len_q       <= '0;
         tx_len_beats_q <= '0;
         tx_beats_q     <= '0;
         pat_q          <= 32'd1;
         mode_q         <= 1'b0;
         ack_q          <= 1'b0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (CHNL_RX) begin
                  ack_q       <= 1'b1;
                  len_q       <= CHNL_RX_LEN;
                  len_beats_q <= rx_len_beats_c;
                  mode_q      <= MODE;
                  rx_beats_q  <= '0;
                  if (CHNL_RX_LEN == 32'd0) begin
                     tx_len_q       <= '0;
                     tx_len_beats_q <= '0;
                  end
               end
            end
            S_RX: begin
               rx_beats_q <= rx_beats_nx;
               if (rx_done || rx_abort) begin
                  tx_len_q       <= tx_len_nx;
                  tx_len_beats_q <= tx_len_beats_nx;
               end
            end
            S_TX_REQ: begin
               tx_beats_q <= '0;
               pat_q      <= 32'd1;
            end
            S_TX_DATA: begin
               if (tx_xfer) begin
                  tx_beats_q <= tx_beats_q + 32'd1;
                  pat_q      <= pat_q + 32'(W);
               end
            end
            default: ;
         endcase
         if (fifo_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (tx_xfer && !mode_q) rd_ptr_q <= rd_ptr_q + PW'(1);
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (fifo_wr) mem[wr_ptr_q[FIFO_ADDR_W-1:0]] <= CHNL_RX_DATA;
   end

`ifdef IOB_PCIE_LOOPBACK_STATS_EN
   // Transaction statistics, free-running with 32-bit wrap
   always_ff @(posedge CLK) begin
      if (RST) begin
         XFER_CNT  <= '0;
         TRUNC_CNT <= '0;
         ABORT_CNT <= '0;
      end else begin
         if (tx_fin || ((state_q == S_TX_REQ) && CHNL_TX_ACK && (tx_len_q == 32'd0)))
            XFER_CNT <= XFER_CNT + 32'd1;
         if ((state_q == S_IDLE) && CHNL_RX && (34'(CHNL_RX_LEN) > CAP_WORDS))
            TRUNC_CNT <= TRUNC_CNT + 32'd1;
         if (rx_abort)
            ABORT_CNT <= ABORT_CNT + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_iob_pcie_loopback.sv
// Directed bench for iob_pcie_loopback at W=1 (4-beat FIFO), W=2 and W=4 sharing one stimulus bus.
// Counters are checked when IOB_PCIE_LOOPBACK_STATS_EN is defined.
module tb_iob_pcie_loopback;

   logic         clk      = 1'b0;
   logic         rst      = 1'b1;
   logic         chnl_rx  = 1'b0;
   logic [31:0]  rx_len   = '0;
   logic [30:0]  rx_off   = 31'h1234;
   logic         rx_lastb = 1'b1;
   logic [127:0] rx_data  = '0;
   logic         rx_valid = 1'b0;
   logic         tx_ack   = 1'b0;
   logic         tx_ren   = 1'b0;
   logic         mode     = 1'b0;

   logic         rx_clk   [3];
   logic         tx_clk   [3];
   logic         rx_ack   [3];
   logic         rx_ren   [3];
   logic         tx_req   [3];
   logic         tx_last  [3];
   logic         tx_valid [3];
   logic         busy     [3];
   logic [31:0]  tx_len   [3];
   logic [30:0]  tx_off   [3];
   logic [31:0]  tx_data1;
   logic [63:0]  tx_data2;
   logic [127:0] tx_data4;
`ifdef IOB_PCIE_LOOPBACK_STATS_EN
   logic [31:0]  xfer_cnt  [3];
   logic [31:0]  trunc_cnt [3];
   logic [31:0]  abort_cnt [3];
`endif

   int           sel = 0;
   int           n_checks = 0;
   int           n_fail = 0;
   logic [127:0] tx_data_m;
   logic [31:0]  words [$];
   logic [127:0] exp_q [$];

   always #5 clk = ~clk;

   iob_pcie_loopback #(.C_PCI_DATA_WIDTH(32), .FIFO_ADDR_W(2)) u_w1 (
      .CLK(clk), .RST(rst), .CHNL_RX_CLK(rx_clk[0]), .CHNL_RX(chnl_rx), .CHNL_RX_ACK(rx_ack[0]),
      .CHNL_RX_LAST(rx_lastb), .CHNL_RX_LEN(rx_len), .CHNL_RX_OFF(rx_off), .CHNL_RX_DATA(rx_data[31:0]),
      .CHNL_RX_DATA_VALID(rx_valid), .CHNL_RX_DATA_REN(rx_ren[0]), .CHNL_TX_CLK(tx_clk[0]),
      .CHNL_TX(tx_req[0]), .CHNL_TX_ACK(tx_ack), .CHNL_TX_LAST(tx_last[0]), .CHNL_TX_LEN(tx_len[0]),
      .CHNL_TX_OFF(tx_off[0]), .CHNL_TX_DATA(tx_data1), .CHNL_TX_DATA_VALID(tx_valid[0]),
      .CHNL_TX_DATA_REN(tx_ren), .MODE(mode), .BUSY(busy[0])
`ifdef IOB_PCIE_LOOPBACK_STATS_EN
      , .XFER_CNT(xfer_cnt[0]), .TRUNC_CNT(trunc_cnt[0]), .ABORT_CNT(abort_cnt[0])
`endif
   );

   iob_pcie_loopback #(.C_PCI_DATA_WIDTH(64), .FIFO_ADDR_W(3)) u_w2 (
      .CLK(clk), .RST(rst), .CHNL_RX_CLK(rx_clk[1]), .CHNL_RX(chnl_rx), .CHNL_RX_ACK(rx_ack[1]),
      .CHNL_RX_LAST(rx_lastb), .CHNL_RX_LEN(rx_len), .CHNL_RX_OFF(rx_off), .CHNL_RX_DATA(rx_data[63:0]),
      .CHNL_RX_DATA_VALID(rx_valid), .CHNL_RX_DATA_REN(rx_ren[1]), .CHNL_TX_CLK(tx_clk[1]),
      .CHNL_TX(tx_req[1]), .CHNL_TX_ACK(tx_ack), .CHNL_TX_LAST(tx_last[1]), .CHNL_TX_LEN(tx_len[1]),
      .CHNL_TX_OFF(tx_off[1]), .CHNL_TX_DATA(tx_data2), .CHNL_TX_DATA_VALID(tx_valid[1]),
      .CHNL_TX_DATA_REN(tx_ren), .MODE(mode), .BUSY(busy[1])
`ifdef IOB_PCIE_LOOPBACK_STATS_EN
      , .XFER_CNT(xfer_cnt[1]), .TRUNC_CNT(trunc_cnt[1]), .ABORT_CNT(abort_cnt[1])
`endif
   );

   iob_pcie_loopback #(.C_PCI_DATA_WIDTH(128), .FIFO_ADDR_W(3)) u_w4 (
      .CLK(clk), .RST(rst), .CHNL_RX_CLK(rx_clk[2]), .CHNL_RX(chnl_rx), .CHNL_RX_ACK(rx_ack[2]),
      .CHNL_RX_LAST(rx_lastb), .CHNL_RX_LEN(rx_len), .CHNL_RX_OFF(rx_off), .CHNL_RX_DATA(rx_data),
      .CHNL_RX_DATA_VALID(rx_valid), .CHNL_RX_DATA_REN(rx_ren[2]), .CHNL_TX_CLK(tx_clk[2]),
      .CHNL_TX(tx_req[2]), .CHNL_TX_ACK(tx_ack), .CHNL_TX_LAST(tx_last[2]), .CHNL_TX_LEN(tx_len[2]),
      .CHNL_TX_OFF(tx_off[2]), .CHNL_TX_DATA(tx_data4), .CHNL_TX_DATA_VALID(tx_valid[2]),
      .CHNL_TX_DATA_REN(tx_ren), .MODE(mode), .BUSY(busy[2])
`ifdef IOB_PCIE_LOOPBACK_STATS_EN
      , .XFER_CNT(xfer_cnt[2]), .TRUNC_CNT(trunc_cnt[2]), .ABORT_CNT(abort_cnt[2])
`endif
   );

   always_comb begin
      case (sel)
         0:       tx_data_m = {96'd0, tx_data1};
         1:       tx_data_m = {64'd0, tx_data2};
         default: tx_data_m = tx_data4;
      endcase
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int wcur();
      return (sel == 0) ? 1 : ((sel == 1) ? 2 : 4);
   endfunction

   function automatic logic [127:0] pack_beat(input int b);
      logic [127:0] v;
      int idx;
      v = '0;
      for (int i = 0; i < wcur(); i++) begin
         idx = b * wcur() + i;
         v[i*32 +: 32] = (idx < words.size()) ? words[idx] : 32'hDEAD_BEEF;
      end
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; chnl_rx = 1'b0; rx_valid = 1'b0; tx_ack = 1'b0; tx_ren = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Request an RX transaction of len words and stream nb beats, then drop CHNL_RX
   task automatic rx_send(input string tag, input int len, input bit md, input int nb);
      int guard;
      @(negedge clk);
      chnl_rx = 1'b1; rx_len = 32'(len); mode = md;
      @(negedge clk);
      guard = 0;
      while (!rx_ack[sel] && guard < 20) begin @(negedge clk); guard++; end
      check({tag, "_rx_ack"}, 128'(rx_ack[sel]), 128'd1);
      for (int b = 0; b < nb; b++) begin
         guard = 0;
         while (!rx_ren[sel] && guard < 20) begin @(negedge clk); guard++; end
         rx_data  = pack_beat(b);
         rx_valid = 1'b1;
         @(negedge clk);
      end
      rx_valid = 1'b0; chnl_rx = 1'b0; rx_data = '0;
   endtask

   // Accept the TX request and collect exp_q.size() beats, optionally stalling REN every other cycle
   task automatic tx_recv(input string tag, input int exp_len, input bit stall);
      int guard;
      int k;
      guard = 0; k = 0;
      while (!tx_req[sel] && guard < 50) begin @(negedge clk); guard++; end
      check({tag, "_tx_req"}, 128'(tx_req[sel]), 128'd1);
      check({tag, "_tx_len"}, 128'(tx_len[sel]), 128'(exp_len));
      check({tag, "_valid_in_req"}, 128'(tx_valid[sel]), 128'd0);
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
      guard = 0;
      while (k < exp_q.size() && guard < 100) begin
         tx_ren = stall ? ((guard % 2) == 0) : 1'b1;
         if (tx_valid[sel] && tx_ren) begin
            check($sformatf("%s_beat%0d", tag, k), tx_data_m, exp_q[k]);
            check({tag, "_tx_held"}, 128'(tx_req[sel]), 128'd1);
            k++;
         end
         @(negedge clk);
         guard++;
      end
      tx_ren = 1'b0;
      check({tag, "_beat_count"}, 128'(k), 128'(exp_q.size()));
      check({tag, "_tx_done"}, 128'(tx_req[sel]), 128'd0);
      check({tag, "_valid_done"}, 128'(tx_valid[sel]), 128'd0);
      check({tag, "_busy_done"}, 128'(busy[sel]), 128'd0);
   endtask

   initial begin
      do_reset();
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check($sformatf("rst%0d_ack", s), 128'(rx_ack[s]), 128'd0);
         check($sformatf("rst%0d_ren", s), 128'(rx_ren[s]), 128'd0);
         check($sformatf("rst%0d_tx", s), 128'(tx_req[s]), 128'd0);
         check($sformatf("rst%0d_valid", s), 128'(tx_valid[s]), 128'd0);
         check($sformatf("rst%0d_busy", s), 128'(busy[s]), 128'd0);
         check($sformatf("rst%0d_len", s), 128'(tx_len[s]), 128'd0);
         check($sformatf("rst%0d_data", s), tx_data_m, 128'd0);
         check($sformatf("rst%0d_last", s), 128'(tx_last[s]), 128'd1);
         check($sformatf("rst%0d_off", s), 128'(tx_off[s]), 128'd0);
         check($sformatf("rst%0d_rxclk", s), 128'(rx_clk[s]), 128'(clk));
         check($sformatf("rst%0d_txclk", s), 128'(tx_clk[s]), 128'(clk));
      end

      // W=2 echo, 5 words, REN stalled every other cycle
      sel = 1; do_reset();
      words = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
      exp_q = '{128'h0000_0000_0000_0000_A000_0001_A000_0000,
                128'h0000_0000_0000_0000_A000_0003_A000_0002,
                128'h0000_0000_0000_0000_0000_0000_A000_0004};
      rx_send("t1", 5, 1'b0, 3);
      tx_recv("t1", 5, 1'b1);

      // W=4 pattern, 8 words
      sel = 2; do_reset();
      words = '{};
      exp_q = '{128'h0000_0004_0000_0003_0000_0002_0000_0001,
                128'h0000_0008_0000_0007_0000_0006_0000_0005};
      rx_send("t2", 8, 1'b1, 2);
      tx_recv("t2", 8, 1'b0);

      // W=1, 4-word FIFO, 6 words: truncated to 4
      sel = 0; do_reset();
      words = '{32'h3000_0000, 32'h3000_0001, 32'h3000_0002, 32'h3000_0003, 32'h3000_0004, 32'h3000_0005};
      exp_q = '{128'h3000_0000, 128'h3000_0001, 128'h3000_0002, 128'h3000_0003};
      rx_send("t3", 6, 1'b0, 6);
      tx_recv("t3", 4, 1'b0);
`ifdef IOB_PCIE_LOOPBACK_STATS_EN
      check("t3_trunc_cnt", 128'(trunc_cnt[0]), 128'd1);
      check("t3_xfer_cnt", 128'(xfer_cnt[0]), 128'd1);
`endif

      // Zero-length transaction
      sel = 0; do_reset();
      exp_q = '{};
      rx_send("t4", 0, 1'b0, 0);
      @(negedge clk);
      check("t4_ack_pulse", 128'(rx_ack[0]), 128'd0);
      tx_recv("t4", 0, 1'b0);
`ifdef IOB_PCIE_LOOPBACK_STATS_EN
      check("t4_xfer_cnt", 128'(xfer_cnt[0]), 128'd1);
`endif

      // Abort after 3 of 8 beats
      sel = 0; do_reset();
      words = '{32'h5000_0000, 32'h5000_0001, 32'h5000_0002};
      exp_q = '{128'h5000_0000, 128'h5000_0001, 128'h5000_0002};
      rx_send("t5", 8, 1'b0, 3);
      tx_recv("t5", 3, 1'b0);
`ifdef IOB_PCIE_LOOPBACK_STATS_EN
      check("t5_abort_cnt", 128'(abort_cnt[0]), 128'd1);
      check("t5_trunc_cnt", 128'(trunc_cnt[0]), 128'd1);
`endif

      // W=2 echo, reset mid-TX, then a normal transaction
      sel = 1; do_reset();
      words = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003};
      rx_send("t6", 4, 1'b0, 2);
      begin
         int guard;
         guard = 0;
         while (!tx_req[1] && guard < 50) begin @(negedge clk); guard++; end
         check("t6_tx_len", 128'(tx_len[1]), 128'd4);
         tx_ack = 1'b1;
         @(negedge clk);
         tx_ack = 1'b0;
         tx_ren = 1'b1;
         check("t6_valid0", 128'(tx_valid[1]), 128'd1);
         check("t6_beat0", tx_data_m, 128'h0000_0000_0000_0000_B000_0001_B000_0000);
         @(negedge clk);
         tx_ren = 1'b0;
         check("t6_valid1", 128'(tx_valid[1]), 128'd1);
         check("t6_beat1", tx_data_m, 128'h0000_0000_0000_0000_B000_0003_B000_0002);
         @(negedge clk);
         check("t6_beat1_held", tx_data_m, 128'h0000_0000_0000_0000_B000_0003_B000_0002);
         rst = 1'b1; tx_ren = 1'b1;
         @(negedge clk);
         check("t6_rst_ack", 128'(rx_ack[1]), 128'd0);
         check("t6_rst_ren", 128'(rx_ren[1]), 128'd0);
         check("t6_rst_tx", 128'(tx_req[1]), 128'd0);
         check("t6_rst_valid", 128'(tx_valid[1]), 128'd0);
         check("t6_rst_busy", 128'(busy[1]), 128'd0);
         check("t6_rst_len", 128'(tx_len[1]), 128'd0);
         check("t6_rst_data", tx_data_m, 128'd0);
         rst = 1'b0; tx_ren = 1'b0;
      end
      words = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002};
      exp_q = '{128'h0000_0000_0000_0000_C000_0001_C000_0000,
                128'h0000_0000_0000_0000_0000_0000_C000_0002};
      rx_send("t7", 3, 1'b0, 2);
      tx_recv("t7", 3, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
